// File: rtl/clk_rst_spi_unit_if.sv
// SPI link between an SPI master and the clk_rst_spi_unit slave responder.
// Carries the serial pins plus the parallel word ports on the responder side.
interface clk_rst_spi_unit_if #(
    parameter int SPI_WIDTH = 8
);
    logic                 sclk;
    logic                 cs;
    logic                 mosi;
    logic                 miso;
    logic [SPI_WIDTH-1:0] tx_data;
    logic [SPI_WIDTH-1:0] rx_data;
    logic                 rx_valid;

    modport slave  (input  sclk, cs, mosi, tx_data, output miso, rx_data, rx_valid);
    modport master (output sclk, cs, mosi, tx_data, input  miso, rx_data, rx_valid);
endinterface

// File: rtl/clk_rst_spi_unit.sv
// Programmable gated clock generator, delayed reset sequencer and mode-0 SPI slave.
// Optional SPI_LOOPBACK_EN: TX reloads echo the most recently received word.
module clk_rst_spi_unit #(
    parameter int RST_HOLD_CYCLES = 16,
    parameter int SPI_WIDTH       = 8,
    parameter int MIN_PERIOD      = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     run_clock,
    input  logic [31:0]              clock_period,
    output logic                     gen_clk,
    output logic                     gen_rst_n,
    clk_rst_spi_unit_if.slave        spi
);
    localparam int RCW = $clog2(RST_HOLD_CYCLES + 1);
    localparam int BCW = $clog2(SPI_WIDTH + 1);

    // ---------------- clock generator ----------------
    typedef enum logic [1:0] {CG_IDLE, CG_HIGH, CG_LOW} cg_state_t;

    cg_state_t   state, state_d;
    logic [31:0] cnt, cnt_d;
    logic [31:0] lat_p, lat_d;
    logic [31:0] eff_p, hi_len, lo_len;
    logic        gen_clk_q;

    assign eff_p  = (clock_period < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : clock_period;
    assign hi_len = lat_p >> 1;
    assign lo_len = lat_p - hi_len;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= CG_IDLE;
            cnt       <= '0;
            lat_p     <= '0;
            gen_clk_q <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            lat_p     <= lat_d;
            gen_clk_q <= (state_d == CG_HIGH);
        end
    end

    // Phases always run to completion, so neither level can be cut short.
    always_comb begin
        state_d = state;
        cnt_d   = cnt + 32'd1;
        lat_d   = lat_p;
        case (state)
            CG_IDLE: begin
                cnt_d = '0;
                if (run_clock) begin
                    state_d = CG_HIGH;
                    cnt_d   = 32'd1;
                    lat_d   = eff_p;
                end
            end
            CG_HIGH: begin
                if (cnt >= hi_len) begin
                    state_d = CG_LOW;
                    cnt_d   = 32'd1;
                end
            end
            CG_LOW: begin
                if (cnt >= lo_len) begin
                    if (run_clock) begin
                        state_d = CG_HIGH;
                        cnt_d   = 32'd1;
                        lat_d   = eff_p;
                    end else begin
                        state_d = CG_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = CG_IDLE;
        endcase
    end

    assign gen_clk = gen_clk_q;

    // ---------------- reset sequencer ----------------
    logic [RCW-1:0] rst_cnt;
    logic           gen_rst_n_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rst_cnt     <= '0;
            gen_rst_n_q <= 1'b0;
        end else begin
            if (rst_cnt != RCW'(RST_HOLD_CYCLES)) rst_cnt <= rst_cnt + 1'b1;
            gen_rst_n_q <= (rst_cnt >= RCW'(RST_HOLD_CYCLES - 1));
        end
    end

    assign gen_rst_n = gen_rst_n_q;

    // ---------------- SPI slave ----------------
    // [0],[1] synchronize; [2] is the previous synchronized value for edge detection.
    logic [2:0]           sclk_q, cs_q;
    logic [1:0]           mosi_q;
    logic [SPI_WIDTH-1:0] tx_sr, rx_data_q, rx_word, cs_load, end_load;
    logic [SPI_WIDTH-2:0] rx_sr;
    logic [BCW-1:0]       bit_cnt;
    logic                 miso_q, rx_valid_q;
    logic                 sclk_rise, sclk_fall, cs_fall, sel;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign sel       = ~cs_q[1];
    assign rx_word   = {rx_sr, mosi_q[1]};

`ifdef SPI_LOOPBACK_EN
    assign cs_load  = rx_data_q;
    assign end_load = rx_word;
`else
    assign cs_load  = spi.tx_data;
    assign end_load = spi.tx_data;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            sclk_q     <= '0;
            cs_q       <= '0;
            mosi_q     <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            rx_data_q  <= '0;
            bit_cnt    <= '0;
            miso_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            sclk_q     <= {sclk_q[1:0], spi.sclk};
            cs_q       <= {cs_q[1:0], spi.cs};
            mosi_q     <= {mosi_q[0], spi.mosi};
            rx_valid_q <= 1'b0;
            if (cs_fall) begin
                tx_sr   <= cs_load;
                miso_q  <= cs_load[SPI_WIDTH-1];
                bit_cnt <= '0;
                rx_sr   <= '0;
            end else if (!sel) begin
                bit_cnt <= '0;
                rx_sr   <= '0;
                miso_q  <= 1'b0;
            end else if (sclk_rise) begin
                if (bit_cnt == BCW'(SPI_WIDTH - 1)) begin
                    rx_data_q  <= rx_word;
                    rx_valid_q <= 1'b1;
                    tx_sr      <= end_load;
                    bit_cnt    <= '0;
                end else begin
                    rx_sr   <= rx_word[SPI_WIDTH-2:0];
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (sclk_fall) begin
                // A freshly reloaded word presents its MSB without shifting.
                if (bit_cnt == '0) begin
                    miso_q <= tx_sr[SPI_WIDTH-1];
                end else begin
                    miso_q <= tx_sr[SPI_WIDTH-2];
                    tx_sr  <= tx_sr << 1;
                end
            end
        end
    end

    assign spi.miso     = miso_q;
    assign spi.rx_data  = rx_data_q;
    assign spi.rx_valid = rx_valid_q;
endmodule

// File: tb/tb_clk_rst_spi_unit.sv
// Randomized self-checking bench for clk_rst_spi_unit against a phase-length
// and word-level reference model.
`timescale 1ns/1ps
module tb_clk_rst_spi_unit;
    localparam int HOLD = 16;
    localparam int W    = 8;
`ifdef SPI_LOOPBACK_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        run_clock = 1'b0;
    logic [31:0] clock_period = '0;
    logic        gen_clk, gen_rst_n;

    int total = 0;
    int bad   = 0;
    int vld_cnt = 0;
    logic [W-1:0] last_rx = '0;
    logic [W-1:0] fr_mo [4];
    logic [W-1:0] fr_tx [5];

    clk_rst_spi_unit_if #(.SPI_WIDTH(W)) sif ();

    clk_rst_spi_unit #(.RST_HOLD_CYCLES(HOLD), .SPI_WIDTH(W), .MIN_PERIOD(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .run_clock    (run_clock),
        .clock_period (clock_period),
        .gen_clk      (gen_clk),
        .gen_rst_n    (gen_rst_n),
        .spi          (sif.slave)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (sif.rx_valid === 1'b1) vld_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Counts consecutive samples at level lvl, giving up at max.
    task automatic run_len(input logic lvl, input int max, output int n);
        n = 0;
        while (gen_clk === lvl && n < max) begin
            cyc(1);
            n++;
        end
    endtask

    task automatic rst_release(input string tag);
        int n;
        n = 0;
        reset = 1'b1;
        while (n < 100) begin
            cyc(1);
            n++;
            if (gen_rst_n === 1'b1) break;
        end
        chk(tag, n, HOLD);
    endtask

    task automatic clk_check(input int p);
        int ep, eh, el, h, l;
        ep = (p < 2) ? 2 : p;
        eh = ep / 2;
        el = ep - eh;
        clock_period = p;
        run_clock = 1'b1;
        cyc(1);
        chk($sformatf("cg_start p=%0d", p), gen_clk, 1);
        for (int k = 0; k < 2; k++) begin
            run_len(1'b1, 100, h);
            chk($sformatf("cg_hi p=%0d", p), h, eh);
            if (k == 1) break;
            run_len(1'b0, 100, l);
            chk($sformatf("cg_lo p=%0d", p), l, el);
        end
        run_clock = 1'b0;
        run_len(1'b0, el + 6, l);
        chk($sformatf("cg_park p=%0d", p), l, el + 6);
    endtask

    task automatic spi_bits(input logic [W-1:0] mo, input int nb, input logic [W-1:0] next_tx,
                            output logic [W-1:0] mi);
        mi = '0;
        for (int b = W - 1; b >= W - nb; b--) begin
            sif.mosi = mo[b];
            cyc(4);
            mi[b] = sif.miso;
            sif.sclk = 1'b1;
            if (b == W - 1) sif.tx_data = next_tx;
            cyc(4);
            sif.sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input int nw);
        logic [W-1:0] mi, exp_mi;
        int v0;
        sif.tx_data = fr_tx[0];
        sif.cs = 1'b0;
        cyc(5);
        for (int i = 0; i < nw; i++) begin
            if (LOOP) exp_mi = (i == 0) ? last_rx : fr_mo[i-1];
            else      exp_mi = fr_tx[i];
            v0 = vld_cnt;
            spi_bits(fr_mo[i], W, fr_tx[i+1], mi);
            chk($sformatf("spi_miso w%0d", i), mi, exp_mi);
            chk($sformatf("spi_rx w%0d", i), sif.rx_data, fr_mo[i]);
            chk($sformatf("spi_vld w%0d", i), vld_cnt - v0, 1);
            last_rx = fr_mo[i];
        end
        cyc(4);
        sif.cs = 1'b1;
        cyc(5);
        chk("spi_idle_miso", sif.miso, 0);
    endtask

    initial begin
        logic [W-1:0] mi, txv;
        int h, l, v0;
        sif.sclk = 1'b0;
        sif.cs = 1'b1;
        sif.mosi = 1'b0;
        sif.tx_data = '0;
        cyc(3);
        chk("rst_gen_clk", gen_clk, 0);
        chk("rst_gen_rst_n", gen_rst_n, 0);
        chk("rst_miso", sif.miso, 0);
        chk("rst_rx_data", sif.rx_data, 0);
        chk("rst_rx_valid", sif.rx_valid, 0);

        rst_release("rst_hold");
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(8);
        chk("rst_mid_low", gen_rst_n, 0);
        reset = 1'b0;
        cyc(2);
        chk("rst_abort", gen_rst_n, 0);
        rst_release("rst_restart");

        clk_check(10);
        clk_check(7);
        clk_check(0);
        clk_check(1);
        clk_check(2);
        clk_check(3);
        repeat (6) clk_check(int'($urandom_range(0, 13)));

        // run_clock dropped in the 2nd high cycle
        clock_period = 10;
        run_clock = 1'b1;
        cyc(2);
        run_clock = 1'b0;
        run_len(1'b1, 20, h);
        chk("cg_drop_hi", h, 4);
        run_len(1'b0, 30, l);
        chk("cg_drop_lo", l, 30);
        run_clock = 1'b1;
        cyc(1);
        chk("cg_reraise", gen_clk, 1);
        run_len(1'b1, 20, h);
        run_clock = 1'b0;
        cyc(12);

        // period change mid-high takes effect on the next period
        clock_period = 10;
        run_clock = 1'b1;
        cyc(1);
        clock_period = 4;
        run_len(1'b1, 20, h);
        chk("cg_chg_hi0", h, 5);
        run_len(1'b0, 20, l);
        chk("cg_chg_lo0", l, 5);
        run_len(1'b1, 20, h);
        chk("cg_chg_hi1", h, 2);
        run_clock = 1'b0;
        run_len(1'b0, 10, l);
        chk("cg_chg_park", l, 10);

        // reset while running aborts gen_clk and gen_rst_n
        clock_period = 10;
        run_clock = 1'b1;
        cyc(2);
        reset = 1'b0;
        run_clock = 1'b0;
        cyc(1);
        chk("cg_rst_abort", gen_clk, 0);
        chk("cg_rst_rstn", gen_rst_n, 0);
        rst_release("rst_after_cg");

        fr_mo[0] = 8'hA5;
        fr_tx[0] = 8'h3C;
        fr_tx[1] = 8'h00;
        spi_frame(1);

        fr_mo[0] = 8'h11;
        fr_mo[1] = 8'h22;
        fr_tx[0] = 8'h5A;
        fr_tx[1] = 8'hC3;
        fr_tx[2] = 8'h00;
        spi_frame(2);

        // partial word discarded
        txv = 8'($urandom);
        sif.tx_data = txv;
        sif.cs = 1'b0;
        cyc(5);
        v0 = vld_cnt;
        spi_bits(8'($urandom), 5, 8'h00, mi);
        chk("part_bits", {27'd0, mi[W-1:W-5]}, {27'd0, (LOOP ? last_rx[W-1:W-5] : txv[W-1:W-5])});
        sif.cs = 1'b1;
        cyc(6);
        chk("part_vld", vld_cnt - v0, 0);
        chk("part_rx", sif.rx_data, last_rx);
        chk("part_miso", sif.miso, 0);

        // sclk while deselected is ignored
        v0 = vld_cnt;
        repeat (W) begin
            sif.sclk = 1'b1;
            cyc(4);
            sif.sclk = 1'b0;
            cyc(4);
        end
        chk("desel_vld", vld_cnt - v0, 0);
        chk("desel_miso", sif.miso, 0);

        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 4; i++) fr_mo[i] = 8'($urandom);
            for (int i = 0; i < 5; i++) fr_tx[i] = 8'($urandom);
            spi_frame(int'($urandom_range(1, 3)));
        end

        // reset mid-word clears SPI outputs
        sif.tx_data = 8'hFF;
        sif.cs = 1'b0;
        cyc(5);
        spi_bits(8'hFF, 3, 8'hFF, mi);
        reset = 1'b0;
        cyc(1);
        chk("spi_rst_rx", sif.rx_data, 0);
        chk("spi_rst_miso", sif.miso, 0);
        chk("spi_rst_vld", sif.rx_valid, 0);
        sif.cs = 1'b1;
        sif.sclk = 1'b0;
        last_rx = '0;
        cyc(2);
        rst_release("rst_after_spi");

        for (int i = 0; i < 4; i++) fr_mo[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) fr_tx[i] = 8'($urandom);
        spi_frame(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clk_rst_spi_unit.md
# clk_rst_spi_unit

Testbench-side infrastructure block combining a programmable clock generator, a reset sequencer and an SPI slave responder. It runs on one system clock. It produces a gated, divided clock and a delayed active-low reset for downstream logic. It also terminates an SPI flash-style link: it captures MOSI bytes and returns MISO bytes, standing in for the serial device attached to the SoC's SPI master.

## Interface
- RST_HOLD_CYCLES, 16: system-clock cycles `gen_rst_n` stays low after `reset` releases.
- SPI_WIDTH, 8: bits per SPI word.
- MIN_PERIOD, 2: smallest honoured `clock_period`.

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-low reset.
- run_clock  in  1  enables `gen_clk` toggling.
- clock_period  in  32  `gen_clk` period, in `clock` cycles.
- gen_clk  out  1  generated clock.
- gen_rst_n  out  1  generated active-low reset.
- sclk  in  1  SPI serial clock (asynchronous).
- cs  in  1  SPI chip select, active-low (asynchronous).
- mosi  in  1  SPI data from master.
- miso  out  1  SPI data to master.
- tx_data  in  SPI_WIDTH  word returned on the next transfer.
- rx_data  out  SPI_WIDTH  last complete received word.
- rx_valid  out  1  one-cycle pulse when `rx_data` updates.

## Operation
- Reset (`reset`=0 at a clock edge) sets: `gen_clk`=0, `gen_rst_n`=0, `miso`=0, `rx_data`=0, `rx_valid`=0, all counters and shift registers 0.
- Clock generator:
  - Effective period P = max(`clock_period`, MIN_PERIOD).
  - High phase is floor(P/2) cycles; low phase is P − floor(P/2) cycles.
  - P is latched only at the start of each high phase. Changes mid-period take effect at the next period.
  - `run_clock`=0 while high: the high phase completes, then `gen_clk` parks low.
  - `run_clock`=0 while low: `gen_clk` stays low.
  - `run_clock` rising: the first high phase starts on the next cycle. No runt pulses, ever.
- Reset sequencer: after `reset` returns to 1, a counter runs for RST_HOLD_CYCLES cycles, then `gen_rst_n` goes to 1. It is independent of `run_clock`.
- SPI slave, mode 0:
  - `sclk`, `cs` and `mosi` each pass through a 2-flop synchronizer, followed by edge detection.
  - `cs` falling: load the TX shift register from `tx_data`, drive its MSB on `miso`, clear the bit counter.
  - Synchronized `sclk` rise with `cs`=0: shift synchronized `mosi` into the RX shift register, MSB first, and increment the bit counter.
  - Synchronized `sclk` fall with `cs`=0: shift TX and drive the next bit on `miso`.
  - After SPI_WIDTH bits: `rx_data` ← RX shift register, pulse `rx_valid`, reload TX from `tx_data`, clear the counter. Back-to-back words are supported without a `cs` toggle.
  - `cs` rising mid-word: discard the partial word, no `rx_valid`, `miso` ← 0.
  - `miso` is 0 whenever `cs`=1.
  - `sclk` edges while `cs`=1 are ignored.

## Timing
- `gen_clk` first goes high on the cycle after `run_clock` is sampled 1.
- `gen_rst_n` rises exactly RST_HOLD_CYCLES cycles after the first cycle with `reset`=1.
- SPI input-to-action latency is 3 `clock` cycles (2 sync + 1 edge-detect register).
- `sclk` high and low times must each be ≥ 3 `clock` cycles; `cs` setup to the first `sclk` edge must be ≥ 4 cycles.
- `rx_valid` is high for exactly one cycle, the cycle after the last bit's sample. `rx_data` is stable until the next word completes.
- `reset` asserted mid-operation aborts everything on the same edge and returns all outputs to reset values.

## Configuration
- SPI_LOOPBACK_EN:
  - Defined: each TX reload (on `cs` fall and at word end) uses the most recently received `rx_data` instead of `tx_data`, so the master reads back the previous word. After reset this is 0.
  - Undefined: TX always loads from `tx_data`.

## Test plan
- `clock_period`=10, `run_clock`=1 → `gen_clk` is 5 high / 5 low. `clock_period`=7 → 3 high / 4 low. `clock_period`=0 → 1 high / 1 low.
- Drop `run_clock` on the 2nd cycle of a high phase with P=10 → `gen_clk` stays high 3 more cycles, then remains 0. Re-raise → high the next cycle.
- Release `reset` with RST_HOLD_CYCLES=16 → `gen_rst_n` rises at cycle 16. Assert `reset` at cycle 8 → `gen_rst_n` stays 0 and the count restarts.
- SPI transfer, `sclk` period 8 cycles, master sends 0xA5, `tx_data`=0x3C → `rx_data`=0xA5 with one `rx_valid` pulse; master samples 0x3C on MISO.
- `cs` deasserted after 5 bits → no `rx_valid`, `rx_data` unchanged, `miso`=0.
- With SPI_LOOPBACK_EN, send 0x11 then 0x22 in one `cs` frame → master reads 0x00 then 0x11.
